// File: rtl/mult_useq_rc.sv
// mult_useq_rc: unsigned shift-add multiplier retiring one partial product per
// cycle, with an optional mod-3 residue check of the finished accumulator.
module mult_useq_rc #(
  parameter int WIDTH    = 4,
  parameter int CHECK_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               inj,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               fault,
  output logic [7:0]         fault_cnt
);

  localparam int PW     = 2 * WIDTH;
  localparam int STEP_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              fault_q, fault_d;
  logic [7:0]        fault_cnt_q, fault_cnt_d;

  logic              b_bit;
  logic [PW-1:0]     addend;
  logic [PW-1:0]     acc_sum;
  logic [1:0]        res_a;
  logic [1:0]        res_b;
  logic [1:0]        res_ab;
  logic [1:0]        res_acc;

  function automatic logic [1:0] mod3_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // 2^k mod 3 alternates 1,2,1,2,... so the residue is a weighted bit sum.
  function automatic logic [1:0] mod3_of(input logic [PW-1:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < PW; i++) begin
      if (v[i]) r = mod3_add(r, ((i % 2) == 0) ? 2'd1 : 2'd2);
    end
    return r;
  endfunction

  always_comb begin
    res_a   = mod3_of(PW'(a_q));
    res_b   = mod3_of(PW'(b_q));
    res_acc = mod3_of(acc_q);
    if (res_a == 2'd0 || res_b == 2'd0) begin
      res_ab = 2'd0;
    end else if (res_a == res_b) begin
      res_ab = 2'd1;
    end else begin
      res_ab = 2'd2;
    end
  end

  always_comb begin
    b_bit   = |(b_q & (WIDTH'(1) << step_q));
    addend  = b_bit ? (PW'(a_q) << step_q) : '0;
    acc_sum = acc_q + addend;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    step_d      = step_q;
    fault_d     = fault_q;
    fault_cnt_d = fault_cnt_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          step_d  = '0;
          fault_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = {acc_sum[PW-1:1], acc_sum[0] ^ inj};
        step_d = step_q + 1'b1;
        if (step_q == LAST_STEP) begin
          step_d  = '0;
          state_d = (CHECK_EN != 0) ? CHECK : DONE;
        end
      end
      CHECK: begin
        fault_d = (CHECK_EN != 0) && (res_ab != res_acc);
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (fault_q && fault_cnt_q != 8'hFF) fault_cnt_d = fault_cnt_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      step_q      <= '0;
      fault_q     <= 1'b0;
      fault_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      fault_q     <= fault_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign product   = acc_q;
  assign fault     = (CHECK_EN != 0) && fault_q && (state_q == DONE);
  assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_mult_useq_rc.sv
// Self-checking bench for mult_useq_rc: a WIDTH=4 checked instance and a
// WIDTH=8 unchecked instance, compared against an arithmetic reference model.
module tb_mult_useq_rc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;

   logic        iv4 = 1'b0, ir4, inj4 = 1'b0, ov4, or4 = 1'b0, f4;
   logic [3:0]  a4 = '0, b4 = '0;
   logic [7:0]  p4, fc4;

   logic        iv8 = 1'b0, ir8, inj8 = 1'b0, ov8, or8 = 1'b0, f8;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] p8;
   logic [7:0]  fc8;

   int testsRun = 0;
   int failCnt  = 0;
   int cnt4     = 0;
   int cnt8     = 0;

   mult_useq_rc #(.WIDTH(4), .CHECK_EN(1)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .inj(inj4), .out_valid(ov4), .out_ready(or4), .product(p4), .fault(f4),
      .fault_cnt(fc4)
   );

   mult_useq_rc #(.WIDTH(8), .CHECK_EN(0)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .inj(inj8), .out_valid(ov8), .out_ready(or8), .product(p8), .fault(f8),
      .fault_cnt(fc8)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Hard stop in case something stalls beyond every bounded wait.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCnt++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic setInputs(input bit wide, input logic iv, input logic [7:0] av, input logic [7:0] bv,
                            input logic ij, input logic ordy);
      if (wide) begin
         iv8 = iv; a8 = av; b8 = bv; inj8 = ij; or8 = ordy;
      end else begin
         iv4 = iv; a4 = av[3:0]; b4 = bv[3:0]; inj4 = ij; or4 = ordy;
      end
   endtask

   function automatic logic rdIr(input bit wide); return wide ? ir8 : ir4; endfunction
   function automatic logic rdOv(input bit wide); return wide ? ov8 : ov4; endfunction
   function automatic logic rdF(input bit wide);  return wide ? f8 : f4;   endfunction
   function automatic logic [15:0] rdP(input bit wide); return wide ? p8 : {8'd0, p4}; endfunction
   function automatic logic [7:0] rdFc(input bit wide); return wide ? fc8 : fc4; endfunction

   // One full operation: accept, run with optional fault injection, hold the
   // result for holdCycles, then handshake and check the aftermath.
   task automatic applyStimulus(input bit wide, input int av, input int bv, input int injStep, input int holdCycles);
      int w;
      int lat;
      longint mask;
      longint expP;
      longint part;
      bit expF;
      int edges;
      int n;
      bit rdyLeak;
      logic ij;

      w    = wide ? 8 : 4;
      lat  = wide ? w + 1 : w + 2;
      mask = (64'd1 << (2 * w)) - 1;
      expP = longint'(av) * longint'(bv);
      if (injStep >= 0) begin
         part = longint'(av) * longint'(bv & ((1 << (injStep + 1)) - 1));
         expP = (part % 2 == 1) ? expP - 1 : expP + 1;
      end
      expP = expP & mask;
      expF = wide ? 1'b0 : ((((av % 3) * (bv % 3)) % 3) != (expP % 3));

      n = 0;
      while (rdIr(wide) !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("in_ready_idle", rdIr(wide), 1);
      setInputs(wide, 1'b1, 8'(av), 8'(bv), 1'b0, 1'b0);
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      rdyLeak = 1'b0;
      while (rdOv(wide) !== 1'b1 && edges < 60) begin
         if (rdIr(wide) !== 1'b0) rdyLeak = 1'b1;
         ij = ((edges - 1) < w) ? ((edges - 1) == injStep) : 1'($urandom % 2);
         setInputs(wide, 1'($urandom % 2), 8'($urandom), 8'($urandom), ij, 1'b0);
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      checkOutput("latency", edges, lat);
      checkOutput("in_ready_busy", rdyLeak, 0);
      setInputs(wide, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

      for (int h = 0; h < holdCycles; h++) begin
         checkOutput("hold_out_valid", rdOv(wide), 1);
         checkOutput("hold_product", rdP(wide), expP);
         checkOutput("hold_fault", rdF(wide), expF);
         checkOutput("hold_in_ready", rdIr(wide), 0);
         setInputs(wide, 1'($urandom % 2), 8'($urandom), 8'($urandom), 1'($urandom % 2), 1'b0);
         @(negedge clk);
      end

      checkOutput("product", rdP(wide), expP);
      checkOutput("fault", rdF(wide), expF);
      checkOutput("in_ready_done", rdIr(wide), 0);
      setInputs(wide, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      if (expF) begin
         if (wide) begin
            if (cnt8 < 255) cnt8++;
         end else begin
            if (cnt4 < 255) cnt4++;
         end
      end
      checkOutput("out_valid_after", rdOv(wide), 0);
      checkOutput("in_ready_after", rdIr(wide), 1);
      checkOutput("fault_cnt", rdFc(wide), wide ? cnt8 : cnt4);
      setInputs(wide, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
   endtask

   // Linear directed sequence followed by randomized operations.
   initial begin
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_in_ready", ir4, 1);
      checkOutput("rst_out_valid", ov4, 0);
      checkOutput("rst_product", p4, 0);
      checkOutput("rst_fault", f4, 0);
      checkOutput("rst_fault_cnt", fc4, 0);
      checkOutput("rst_in_ready_w8", ir8, 1);
      checkOutput("rst_out_valid_w8", ov8, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(1'b0, 15, 15, -1, 0);
      applyStimulus(1'b0, 0, 9, -1, 0);
      applyStimulus(1'b0, 7, 0, -1, 0);
      applyStimulus(1'b0, 6, 5, -1, 10);
      applyStimulus(1'b0, 3, 3, 2, 0);
      applyStimulus(1'b1, 255, 255, -1, 0);

      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, int'($urandom % 16), int'($urandom % 16),
                       ($urandom % 3 == 0) ? int'($urandom % 4) : -1, int'($urandom % 3));
      end
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, int'($urandom % 256), int'($urandom % 256),
                       ($urandom % 3 == 0) ? int'($urandom % 8) : -1, int'($urandom % 3));
      end

      for (int i = 0; i < 260; i++) begin
         applyStimulus(1'b0, int'($urandom % 16), int'($urandom % 16), int'($urandom % 4), 0);
      end
      checkOutput("fault_cnt_saturated", fc4, 255);

      setInputs(1'b0, 1'b1, 8'd5, 8'd5, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      setInputs(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      cnt4 = 0;
      cnt8 = 0;
      checkOutput("midrun_rst_in_ready", ir4, 1);
      checkOutput("midrun_rst_out_valid", ov4, 0);
      checkOutput("midrun_rst_product", p4, 0);
      checkOutput("midrun_rst_fault_cnt", fc4, 0);
      repeat (2) begin
         @(negedge clk);
         checkOutput("midrun_rst_hold_out_valid", ov4, 0);
      end
      rst_n = 1'b1;
      setInputs(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 2, 3, -1, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
      $finish;
   end

endmodule
